// File: rtl/lot_pkg.sv
// Shared definitions for the parking-lot datapath: 7-segment encodings and
// legality checks for the occupancy-stage parameters.
package lot_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_F   = 7'b0001110;

  // Active-low {g,f,e,d,c,b,a}; anything above 9 blanks the digit.
  function automatic logic [6:0] seg_digit(input logic [3:0] value);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (value)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  function automatic bit debounce_ok(input int cycles);
    return (cycles >= 1) && (cycles <= 255);
  endfunction

  function automatic bit capacity_ok(input int capacity, input int cnt_w);
    return (capacity >= 1) && (capacity <= 9) && (cnt_w >= 1) && (cnt_w <= 8) &&
           ((1 << cnt_w) > capacity);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One loop-sensor channel: 2-flop synchroniser, run-length debouncer and a
// rising-edge detector that stays disarmed until the input is seen low.
module sensor_debounce
  import lot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic deb,
  output logic rise
);

  localparam logic [7:0] RUN_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync_a;
  logic       sync_b;
  logic       fill_a;
  logic       fill_b;
  logic       armed;
  logic       deb_q;
  logic [7:0] run_cnt;

  // NOTE: every flop here is state, so it uses non-blocking assignment and
  // the asynchronous active-low reset; blocking '=' would race between blocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      fill_a <= 1'b0;
      fill_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      fill_a <= 1'b1;
      fill_b <= fill_a;
    end
  end

  // A sensor already high at reset release must not count as a car, so edges
  // are only honoured once a genuine low has passed the synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b0;
    end else if (fill_b && !sync_b) begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb     <= 1'b0;
      run_cnt <= 8'd0;
    end else if (sync_b != deb) begin
      if (run_cnt == RUN_LAST) begin
        deb     <= ~deb;
        run_cnt <= 8'd0;
      end else begin
        run_cnt <= run_cnt + 8'd1;
      end
    end else begin
      run_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= 1'b0;
    end else begin
      deb_q <= deb;
    end
  end

  assign rise = deb & ~deb_q & armed;

endmodule

// File: rtl/lot_occupancy.sv
// Occupancy stage: debounced entrance/exit sensors, saturating car count,
// full/empty/reject/underflow flags and the registered free-spaces digit.
module lot_occupancy
  import lot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CAPACITY        = 9,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw_entrance,
  input  logic             raw_exit,
  input  logic             soft_clear,
  output logic             sensor_entrance,
  output logic             sensor_exit,
  output logic [CNT_W-1:0] occupied,
  output logic             full,
  output logic             empty,
  output logic             entry_rejected,
  output logic             err_underflow,
  output logic [6:0]       HEX_FREE
);

  if (!debounce_ok(DEBOUNCE_CYCLES) || !capacity_ok(CAPACITY, CNT_W)) begin : g_param_error
    $error("lot_occupancy: illegal DEBOUNCE_CYCLES/CAPACITY/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic             ent_deb;
  logic             ent_rise;
  logic             ext_deb;
  logic             ext_rise;
  logic             hex_live;
  logic [CNT_W-1:0] free_spaces;
  logic [3:0]       free_digit;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entrance (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw_entrance),
    .deb     (ent_deb),
    .rise    (ent_rise)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw_exit),
    .deb     (ext_deb),
    .rise    (ext_rise)
  );

  assign full  = (occupied == CAP);
  assign empty = (occupied == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupied       <= '0;
      entry_rejected <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      entry_rejected <= 1'b0;
      if (soft_clear) begin
        occupied      <= '0;
        err_underflow <= 1'b0;
      end else if (ent_rise && ext_rise) begin
        // A car in and a car out cancel, even at the full or empty limit.
        occupied <= occupied;
      end else if (ent_rise) begin
        if (full) entry_rejected <= 1'b1;
        else      occupied       <= occupied + CNT_W'(1);
      end else if (ext_rise) begin
        if (empty) err_underflow <= 1'b1;
        else       occupied      <= occupied - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sensor_entrance <= 1'b0;
      sensor_exit     <= 1'b0;
    end else begin
      sensor_entrance <= ent_deb & ~full;
      sensor_exit     <= ext_deb;
    end
  end

  assign free_spaces = CAP - occupied;
  assign free_digit  = 4'(free_spaces);

  // The display stays blank for the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_live <= 1'b0;
      HEX_FREE <= SEG_OFF;
    end else begin
      hex_live <= 1'b1;
      if (hex_live) HEX_FREE <= full ? SEG_F : seg_digit(free_digit);
    end
  end

endmodule

// File: doc/lot_occupancy.md
# lot_occupancy

Sensor-conditioning and occupancy stage placed directly upstream of the gate-control FSM. It synchronises and debounces the raw entrance and exit loop sensors, then forwards clean `sensor_entrance`/`sensor_exit` levels to the gate FSM. It also keeps a saturating count of cars in the lot, masks the entrance request while the lot is full, and drives a 7-segment "free spaces" digit.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a debounced level changes; legal range 1..255.
- `CAPACITY`, default 9: number of parking spaces; legal range 1..9.
- `CNT_W`, default 4: occupancy counter width; must satisfy 2^CNT_W > CAPACITY.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `raw_entrance` in 1: entrance loop sensor; asynchronous, may bounce.
- `raw_exit` in 1: exit loop sensor; asynchronous, may bounce.
- `soft_clear` in 1: synchronous; zeroes the count and the error flags.
- `sensor_entrance` out 1: debounced entrance level AND NOT full; goes to the gate FSM.
- `sensor_exit` out 1: debounced exit level; goes to the gate FSM.
- `occupied` out CNT_W: current car count, 0..CAPACITY.
- `full` out 1: `occupied == CAPACITY`.
- `empty` out 1: `occupied == 0`.
- `entry_rejected` out 1: one-cycle pulse when an entry event is refused because the lot is full.
- `err_underflow` out 1: sticky; set when an exit event is seen while the lot is empty.
- `HEX_FREE` out 7: active-low segments {g,f,e,d,c,b,a} showing free spaces.

## Operation
- Per channel: 2-flop synchroniser, then debouncer.
  - Debouncer holds `deb` and a run counter.
  - Synchronised level ≠ `deb`: the counter increments.
  - Synchronised level = `deb`: the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES−1 and the levels still differ, `deb` toggles on the next edge and the counter clears.
- Events are the rising edges of `deb`: `entry_evt`, `exit_evt`. Falling edges produce no event.
- Count update, priority order:
  1. `soft_clear`: `occupied`←0, `err_underflow`←0. Events in that cycle are discarded.
  2. `entry_evt` and `exit_evt` in the same cycle: count unchanged, no reject, no error. This holds even when the lot is full or empty.
  3. `entry_evt` only: increment if not full. If full, count holds and `entry_rejected` pulses.
  4. `exit_evt` only: decrement if not empty. If empty, count holds and `err_underflow`←1.
- Count never wraps; the range is always 0..CAPACITY.
- `full` and `empty` are decoded from the registered `occupied`.
- `sensor_entrance` and `sensor_exit` are registered.
- `HEX_FREE` is registered:
  - When `full`: "F" = 0001110.
  - Otherwise: digit CAPACITY−occupied, using 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset values:
  - Synchronisers, `deb`, run counters, `occupied`: 0.
  - `sensor_entrance`, `sensor_exit`, `entry_rejected`, `err_underflow`: 0.
  - `HEX_FREE`: 1111111 (all segments off).
- Reset mid-debounce or mid-count discards all partial state. No event is generated on reset release, even if a raw input is already high.

## Timing
- `raw_*` stable from before edge 1: `deb` changes on edge DEBOUNCE_CYCLES+2.
- A raw pulse or glitch shorter than DEBOUNCE_CYCLES cycles after synchronisation produces no `deb` change.
- `entry_evt`/`exit_evt` are asserted combinationally in the cycle after `deb` rises.
- `occupied` updates on the edge that ends the event cycle, DEBOUNCE_CYCLES+3 edges after the raw change.
- `full`, `empty`, `entry_rejected`, `err_underflow` change on that same edge.
- `sensor_entrance`/`sensor_exit` reflect `deb` (and `full`) one edge after `deb` changes.
- `HEX_FREE` lags `occupied` by one edge. First valid display: the second edge after reset release, showing CAPACITY.
- `soft_clear` takes effect on the edge at which it is sampled high.

## Structure
- Shared package `lot_pkg`:
  - `SEG_OFF`, `SEG_F` constants.
  - `seg_digit(4-bit)` → 7-bit active-low encoding function, shared with the gate FSM's HEX encodings.
  - Parameter range checks.
- Sub-module `sensor_debounce` (parameter DEBOUNCE_CYCLES; ports `clk`, `reset_n`, `raw`, `deb`, `rise`) holds the synchroniser, debouncer and rising-edge detect. It is instantiated twice.
- The top level holds the counter, flags and HEX register only.

## Test plan
- Reset release with `raw_entrance`=1: no count change; `sensor_entrance` rises at edge DEBOUNCE_CYCLES+3; `occupied`=0; `HEX_FREE`=0010000 (9) from edge 2.
- Bounce of 3-cycle high pulses on `raw_entrance` (DEBOUNCE_CYCLES=4): `deb` never rises, `occupied` stays 0. A following 10-cycle high gives `occupied`=1 and `HEX_FREE`=0000000 (8).
- Nine clean entries: `occupied`=9, `full`=1, `HEX_FREE`=0001110, `sensor_entrance` held 0. A tenth entry gives one `entry_rejected` pulse and count 9.
- Empty lot, one exit: `err_underflow`=1 (sticky), `occupied`=0. Then `soft_clear` clears the flag.
- Simultaneous entry/exit rising edges at `occupied`=9: count stays 9, no reject. At `occupied`=0: count stays 0, `err_underflow` stays 0.
- `reset_n` low with `occupied`=5 mid-debounce: all outputs return to reset values immediately. No event after release.
